// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with write scoreboard
module decode_stage #(
    parameter int REG_AW = 3,
    parameter int DATA_W = 8,
    parameter int PC_W = 8,
    localparam int INSTR_W = 4 + 3 * REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INSTR_W-1:0] instruction_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [REG_AW-1:0] alu_op_a_addr_o,
    output logic [REG_AW-1:0] alu_op_b_addr_o,
    output logic [2:0]        alu_opcode_o,
    output logic              rd_en_o,
    output logic              wr_en_o,
    output logic [REG_AW-1:0] wr_addr_o,
    output logic              branch_en_o,
    output logic [PC_W-1:0]   branch_addr_o,
    output logic              immediate_en_o,
    output logic [DATA_W-1:0] immediate_o,
    output logic              illegal_o,
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic              flush_i
);
    localparam int NREG = 1 << REG_AW;

    logic              f_class;
    logic [2:0]        f_op;
    logic [REG_AW-1:0] f_a;
    logic [REG_AW-1:0] f_b;
    logic [REG_AW-1:0] f_d;

    assign f_class = instruction_i[INSTR_W-1];
    assign f_op    = instruction_i[INSTR_W-2 -: 3];
    assign f_a     = instruction_i[3*REG_AW-1 -: REG_AW];
    assign f_b     = instruction_i[2*REG_AW-1 -: REG_AW];
    assign f_d     = instruction_i[REG_AW-1:0];

    logic              dec_rd;
    logic              dec_wr;
    logic              dec_br;
    logic              dec_imm;
    logic              dec_ill;
    logic [DATA_W-1:0] dec_imm_val;

    // Classify the incoming word and build the zero-extended immediate
    always_comb begin
        dec_rd      = 1'b0;
        dec_wr      = 1'b0;
        dec_br      = 1'b0;
        dec_imm     = 1'b0;
        dec_ill     = 1'b0;
        dec_imm_val = '0;
        dec_imm_val[2*REG_AW-1:0] = {f_a, f_b};
        if (!f_class) begin
            dec_rd = 1'b1;
            dec_wr = 1'b1;
        end else if (f_op[2:1] == 2'b00) begin
            dec_br = 1'b1;
        end else if (f_op == 3'b010) begin
            dec_imm = 1'b1;
            dec_wr  = 1'b1;
        end else begin
            dec_ill = 1'b1;
        end
    end

    logic [NREG-1:0] pending;
    logic            hazard;
    logic            accept;

    assign hazard = (dec_rd & (pending[f_a] | pending[f_b])) | (dec_wr & pending[f_d]);
    assign in_ready_o = (~out_valid_o | out_ready_i) & ~hazard & ~flush_i;
    assign accept = in_valid_i & in_ready_o;

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // Scoreboard updates: writeback and unissued-flush clears, accepted writes set (set wins)
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (wb_valid_i)
            clr_vec[wb_addr_i] = 1'b1;
        if (flush_i && out_valid_o && wr_en_o && !out_ready_i)
            clr_vec[wr_addr_o] = 1'b1;
        if (accept && dec_wr)
            set_vec[f_d] = 1'b1;
    end

    // Pending-write bit per register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            pending <= '0;
        else
            pending <= (pending & ~clr_vec) | set_vec;
    end

    // Output register: load on accept, drop on flush or handshake, otherwise hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o     <= 1'b0;
            alu_op_a_addr_o <= '0;
            alu_op_b_addr_o <= '0;
            alu_opcode_o    <= '0;
            rd_en_o         <= 1'b0;
            wr_en_o         <= 1'b0;
            wr_addr_o       <= '0;
            branch_en_o     <= 1'b0;
            branch_addr_o   <= '0;
            immediate_en_o  <= 1'b0;
            immediate_o     <= '0;
            illegal_o       <= 1'b0;
        end else if (accept) begin
            out_valid_o     <= 1'b1;
            alu_op_a_addr_o <= f_a;
            alu_op_b_addr_o <= f_b;
            alu_opcode_o    <= f_op;
            rd_en_o         <= dec_rd;
            wr_en_o         <= dec_wr;
            wr_addr_o       <= f_d;
            branch_en_o     <= dec_br;
            branch_addr_o   <= instruction_i[PC_W-1:0];
            immediate_en_o  <= dec_imm;
            immediate_o     <= dec_imm_val;
            illegal_o       <= dec_ill;
        end else if (flush_i || out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage
module tb_decode_stage;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [12:0] instruction_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [2:0]  alu_op_a_addr_o;
    logic [2:0]  alu_op_b_addr_o;
    logic [2:0]  alu_opcode_o;
    logic        rd_en_o;
    logic        wr_en_o;
    logic [2:0]  wr_addr_o;
    logic        branch_en_o;
    logic [7:0]  branch_addr_o;
    logic        immediate_en_o;
    logic [7:0]  immediate_o;
    logic        illegal_o;
    logic        wb_valid_i = 1'b0;
    logic [2:0]  wb_addr_i = '0;
    logic        flush_i = 1'b0;

    decode_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .instruction_i(instruction_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .alu_op_a_addr_o(alu_op_a_addr_o), .alu_op_b_addr_o(alu_op_b_addr_o),
        .alu_opcode_o(alu_opcode_o), .rd_en_o(rd_en_o), .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o), .branch_en_o(branch_en_o), .branch_addr_o(branch_addr_o),
        .immediate_en_o(immediate_en_o), .immediate_o(immediate_o), .illegal_o(illegal_o),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .flush_i(flush_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       rd, wr, br, imm, ill;
        bit [2:0] op, a, b, d;
        bit [7:0] baddr, immv;
    } entry_t;

    int n_checks = 0;
    int n_pass = 0;

    bit     m_pend[8];
    bit     m_valid;
    bit     m_zero;
    entry_t m_ent;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic entry_t decode(input bit [12:0] ins);
        entry_t e;
        int cls = int'(ins[12]);
        int op = int'(ins[11:9]);
        e = '{default: 0};
        e.op = ins[11:9];
        e.a = ins[8:6];
        e.b = ins[5:3];
        e.d = ins[2:0];
        e.baddr = ins[7:0];
        e.immv = 8'(int'(ins[8:6]) * 8 + int'(ins[5:3]));
        if (cls == 0) begin
            e.rd = 1; e.wr = 1;
        end else if (op < 2) begin
            e.br = 1;
        end else if (op == 2) begin
            e.imm = 1; e.wr = 1;
        end else begin
            e.ill = 1;
        end
        return e;
    endfunction

    function automatic bit model_ready();
        entry_t e = decode(instruction_i);
        bit haz = (e.rd && (m_pend[e.a] || m_pend[e.b])) || (e.wr && m_pend[e.d]);
        return (!m_valid || out_ready_i) && !haz && !flush_i;
    endfunction

    task automatic model_update(input bit rdy);
        entry_t e = decode(instruction_i);
        bit acc = in_valid_i && rdy;
        if (rst_i) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_valid = 0;
            m_zero = 1;
            m_ent = '{default: 0};
        end else begin
            if (wb_valid_i) m_pend[wb_addr_i] = 0;
            if (flush_i && m_valid && m_ent.wr && !out_ready_i) m_pend[m_ent.d] = 0;
            if (acc && e.wr) m_pend[e.d] = 1;
            if (acc) begin
                m_valid = 1; m_zero = 0; m_ent = e;
            end else if (flush_i || (m_valid && out_ready_i)) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("out_valid", out_valid_o, m_valid);
        if (m_valid || m_zero) begin
            check_eq("a_addr", alu_op_a_addr_o, m_ent.a);
            check_eq("b_addr", alu_op_b_addr_o, m_ent.b);
            check_eq("opcode", alu_opcode_o, m_ent.op);
            check_eq("wr_addr", wr_addr_o, m_ent.d);
            check_eq("rd_en", rd_en_o, m_ent.rd);
            check_eq("wr_en", wr_en_o, m_ent.wr);
            check_eq("branch_en", branch_en_o, m_ent.br);
            check_eq("imm_en", immediate_en_o, m_ent.imm);
            check_eq("illegal", illegal_o, m_ent.ill);
            if (m_zero || m_ent.br) check_eq("branch_addr", branch_addr_o, m_ent.baddr);
            if (m_zero || m_ent.imm) check_eq("immediate", immediate_o, m_ent.immv);
        end
    endtask

    // Inputs are already applied (at a negedge); check ready, clock, check outputs
    task automatic step();
        bit rdy;
        #1;
        rdy = model_ready();
        check_eq("in_ready", in_ready_o, rdy);
        @(posedge clk_i);
        model_update(rdy);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic drive(input bit rst, input bit iv, input bit [12:0] ins, input bit ordy,
                         input bit wbv, input bit [2:0] wba, input bit fl);
        rst_i = rst; in_valid_i = iv; instruction_i = ins; out_ready_i = ordy;
        wb_valid_i = wbv; wb_addr_i = wba; flush_i = fl;
        step();
    endtask

    initial begin
        @(negedge clk_i);
        drive(1, 0, 13'h0, 0, 0, 0, 0);
        check_eq("rst_out_valid", out_valid_o, 0);
        check_eq("rst_immediate", immediate_o, 0);

        // ALU then RAW on r3
        drive(0, 1, 13'h0053, 0, 0, 0, 0);
        check_eq("alu_wr_addr", wr_addr_o, 3);
        check_eq("alu_rd_en", rd_en_o, 1);
        instruction_i = 13'h00C4; out_ready_i = 1; #1;
        check_eq("raw_stall", in_ready_o, 0);
        drive(0, 1, 13'h00C4, 1, 0, 0, 0);
        drive(0, 1, 13'h00C4, 1, 0, 0, 0);
        drive(0, 1, 13'h00C4, 1, 1, 3, 0);
        #1 check_eq("raw_release", in_ready_o, 1);
        drive(0, 1, 13'h00C4, 1, 1, 4, 0);
        check_eq("raw_accepted_wr", wr_addr_o, 4);

        // load-immediate, branch, illegal
        drive(0, 1, 13'h1551, 1, 1, 4, 0);
        check_eq("li_imm", immediate_o, 8'h2A);
        check_eq("li_en", immediate_en_o, 1);
        drive(0, 1, 13'h10A5, 1, 1, 1, 0);
        check_eq("br_addr", branch_addr_o, 8'hA5);
        check_eq("br_wr_en", wr_en_o, 0);
        drive(0, 1, 13'h1600, 1, 0, 0, 0);
        check_eq("ill_flag", illegal_o, 1);
        check_eq("ill_rd_en", rd_en_o, 0);

        // flush of held ALU entry releases r3
        drive(0, 1, 13'h0053, 1, 0, 0, 0);
        drive(0, 0, 13'h0, 0, 0, 0, 1);
        check_eq("flush_valid", out_valid_o, 0);
        instruction_i = 13'h00C4; flush_i = 0; #1;
        check_eq("flush_cleared_r3", in_ready_o, 1);

        // reset mid-stall
        drive(0, 1, 13'h0053, 0, 0, 0, 0);
        drive(0, 1, 13'h00C4, 0, 0, 0, 0);
        drive(1, 1, 13'h00C4, 0, 0, 0, 0);
        check_eq("rst_stall_valid", out_valid_o, 0);
        check_eq("rst_stall_wr_en", wr_en_o, 0);
        drive(0, 0, 13'h00C4, 0, 0, 0, 0);
        #1 check_eq("rst_scoreboard", in_ready_o, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 300) == 0, ($urandom % 4) != 0, 13'($urandom),
                  ($urandom % 4) != 0, ($urandom % 2) == 0, 3'($urandom),
                  ($urandom % 16) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
